// File: rtl/add_sub_seq.sv
// add_sub_seq: chunk-serial adder/subtractor.
// Each RUN cycle adds one CHUNK-bit slice of the latched operands (LSB slice
// first) and rolls the carry forward. S, Cout, Ovf and Zero are loaded together
// on the edge that finishes the last slice, and they hold until the next
// completion. WIDTH must be a multiple of CHUNK.
module add_sub_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sel_r;
    logic             carry_r;
    logic [IW-1:0]    idx_r;
    logic [WIDTH-1:0] acc_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] csum_s;
    logic             cin_top_s;
    logic             cout_s;
    logic [WIDTH-1:0] chunk_ext_s;
    logic [WIDTH-1:0] acc_next_s;

    // Select the current slice. The operand registers shift right each RUN
    // cycle, so the active slice is always in the low bits. B is inverted for
    // subtraction; the +1 comes from the carry register being preset to Sel.
    always_comb begin
        a_chunk_s = a_r[CHUNK-1:0];
        if (sel_r) begin
            b_chunk_s = ~b_r[CHUNK-1:0];
        end else begin
            b_chunk_s = b_r[CHUNK-1:0];
        end
    end

    // Ripple-add one slice. The loop also records the carry into the slice's
    // top bit. On the last slice that bit is the MSB, and the overflow flag
    // needs the carry into it.
    always_comb begin
        logic c_v;
        c_v       = carry_r;
        csum_s    = {CHUNK{1'b0}};
        cin_top_s = 1'b0;
        for (int j = 0; j < CHUNK; j++) begin
            cin_top_s = c_v;
            csum_s[j] = a_chunk_s[j] ^ b_chunk_s[j] ^ c_v;
            c_v       = (a_chunk_s[j] & b_chunk_s[j]) | (c_v & (a_chunk_s[j] ^ b_chunk_s[j]));
        end
        cout_s = c_v;
    end

    // Shift each new slice sum in at the top of the accumulator. After NCH
    // slices the accumulator holds the whole result in its correct bit order.
    always_comb begin
        chunk_ext_s = WIDTH'(csum_s);
        acc_next_s  = (acc_r >> CHUNK) | (chunk_ext_s << (WIDTH - CHUNK));
    end

    // Control FSM with the datapath registers and registered status outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            sel_r   <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= {IW{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            s_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (Start) begin
                        a_r     <= A;
                        b_r     <= B;
                        sel_r   <= Sel;
                        carry_r <= Sel;
                        idx_r   <= {IW{1'b0}};
                        acc_r   <= {WIDTH{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> CHUNK;
                    b_r     <= b_r >> CHUNK;
                    carry_r <= cout_s;
                    acc_r   <= acc_next_s;
                    idx_r   <= idx_r + IDX_ONE;
                    if (idx_r == IDX_LAST) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        s_r     <= acc_next_s;
                        cout_r  <= cout_s;
                        ovf_r   <= cin_top_s ^ cout_s;
                        zero_r  <= (acc_next_s == {WIDTH{1'b0}});
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy = busy_r;
    assign Done = done_r;
    assign S    = s_r;
    assign Cout = cout_r;
    assign Ovf  = ovf_r;
    assign Zero = zero_r;

endmodule

// File: tb/tb_add_sub_seq.sv
// tb_add_sub_seq: four add_sub_seq instances (8/4, 8/1, 16/8, 8/8) share one
// stimulus stream. Expected results go into a queue per instance when an
// operation is issued, and a monitor pops and checks them whenever Done rises.
module tb_add_sub_seq;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Sel;

    logic [7:0]  s0, s1, s3;
    logic [15:0] s2;
    logic [3:0]  busy_v, done_v, cout_v, ovf_v, zero_v;

    localparam int NCH_K [4] = '{2, 8, 2, 1};
    localparam int W_K   [4] = '{8, 8, 16, 8};

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t q0[$], q1[$], q2[$], q3[$];
    int   bfrom [4];
    int   buntil[4];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    // Clock generation.
    always #5 Clk = ~Clk;

    // Count rising edges so that latency can be measured.
    always @(posedge Clk) cyc <= cyc + 1;

    add_sub_seq #(.WIDTH(8), .CHUNK(4)) u0 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A[7:0]), .B(B[7:0]), .Sel(Sel),
        .Busy(busy_v[0]), .Done(done_v[0]), .S(s0), .Cout(cout_v[0]), .Ovf(ovf_v[0]), .Zero(zero_v[0]));
    add_sub_seq #(.WIDTH(8), .CHUNK(1)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A[7:0]), .B(B[7:0]), .Sel(Sel),
        .Busy(busy_v[1]), .Done(done_v[1]), .S(s1), .Cout(cout_v[1]), .Ovf(ovf_v[1]), .Zero(zero_v[1]));
    add_sub_seq #(.WIDTH(16), .CHUNK(8)) u2 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A), .B(B), .Sel(Sel),
        .Busy(busy_v[2]), .Done(done_v[2]), .S(s2), .Cout(cout_v[2]), .Ovf(ovf_v[2]), .Zero(zero_v[2]));
    add_sub_seq #(.WIDTH(8), .CHUNK(8)) u3 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A[7:0]), .B(B[7:0]), .Sel(Sel),
        .Busy(busy_v[3]), .Done(done_v[3]), .S(s3), .Cout(cout_v[3]), .Ovf(ovf_v[3]), .Zero(zero_v[3]));

    function automatic logic [15:0] s_of(input int k);
        case (k)
            0:       return {8'h00, s0};
            1:       return {8'h00, s1};
            2:       return s2;
            3:       return {8'h00, s3};
            default: return 16'h0000;
        endcase
    endfunction

    // Reference model: plain unsigned and signed integer arithmetic.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic sel);
        exp_t e;
        int m, ua, ub, sa, sb, r, ur;
        m  = (1 << w) - 1;
        ua = int'(a) & m;
        ub = int'(b) & m;
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        r  = sel ? sa - sb : sa + sb;
        ur = sel ? ua - ub : ua + ub;
        e.s    = 16'(ur & m);
        e.cout = sel ? (ua >= ub) : (ur > m);
        e.ovf  = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
        e.zero = ((ur & m) == 0);
        e.cyc  = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] want);
        total = total + 1;
        if (act !== want) begin
            bad = bad + 1;
            $display("FAIL %s dut=%0d got=%0h want=%0h t=%0t", nm, k, act, want, $time);
        end
    endtask

    task automatic push(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            2:       q2.push_back(e);
            3:       q3.push_back(e);
            default: ;
        endcase
    endtask

    task automatic push_k(input int k, input int edge_n, input exp_t e0);
        exp_t e;
        e       = e0;
        e.cyc   = edge_n + NCH_K[k];
        bfrom[k]  = edge_n;
        buntil[k] = edge_n + NCH_K[k] - 1;
        push(k, e);
    endtask

    // Drive a Start request (the caller has already reached a falling edge)
    // and queue the expected results. When use_dir is set, the 8-bit instances
    // take the fixed expected values passed in instead of the model's.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic sel, input bit use_dir,
                            input logic [7:0] ds, input logic dc, input logic dov, input logic dz);
        exp_t e;
        int edge_n;
        A = a; B = b; Sel = sel; Start = 1'b1;
        edge_n = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            e = model(W_K[k], a, b, sel);
            if (use_dir && W_K[k] == 8) begin
                e.s = {8'h00, ds}; e.cout = dc; e.ovf = dov; e.zero = dz;
            end
            push_k(k, edge_n, e);
        end
    endtask

    task automatic end_op();
        @(negedge Clk);
        Start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); Sel = 1'($urandom);
        repeat (12) @(negedge Clk);
    endtask

    task automatic rst_chk(input string nm);
        for (int k = 0; k < 4; k++) begin
            chk({nm, "_busy"}, k, 32'(busy_v[k]), 32'd0);
            chk({nm, "_done"}, k, 32'(done_v[k]), 32'd0);
            chk({nm, "_s"}, k, 32'(s_of(k)), 32'd0);
            chk({nm, "_flags"}, k, 32'({cout_v[k], ovf_v[k], zero_v[k]}), 32'd0);
        end
    endtask

    exp_t me;
    logic have;

    // Monitor: check Busy against the expected RUN window every cycle, and
    // pop and compare a queued result whenever Done is high.
    always @(negedge Clk) begin
        if (Rst_n) begin
            for (int k = 0; k < 4; k++) begin
                chk("busy", k, 32'(busy_v[k]), 32'((cyc >= bfrom[k]) && (cyc <= buntil[k])));
                if (done_v[k]) begin
                    have = 1'b0;
                    case (k)
                        0: if (q0.size() != 0) begin me = q0.pop_front(); have = 1'b1; end
                        1: if (q1.size() != 0) begin me = q1.pop_front(); have = 1'b1; end
                        2: if (q2.size() != 0) begin me = q2.pop_front(); have = 1'b1; end
                        3: if (q3.size() != 0) begin me = q3.pop_front(); have = 1'b1; end
                        default: ;
                    endcase
                    chk("done_expected", k, 32'(have), 32'd1);
                    if (have) begin
                        chk("s", k, 32'(s_of(k)), 32'(me.s));
                        chk("cout_ovf_zero", k, 32'({cout_v[k], ovf_v[k], zero_v[k]}), 32'({me.cout, me.ovf, me.zero}));
                        chk("latency", k, 32'(cyc), 32'(me.cyc));
                    end
                end
            end
        end
    end

    int t0;
    int en;

    initial begin
        Rst_n = 1'b0; Start = 1'b0; A = 16'h0000; B = 16'h0000; Sel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bfrom[k] = 0; buntil[k] = -1;
        end
        repeat (2) @(negedge Clk);
        #1;
        rst_chk("por");

        // Release reset and issue Start on the very first edge after it.
        @(negedge Clk);
        Rst_n = 1'b1;
        start_op(16'h003C, 16'h0005, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0); end_op();
        @(negedge Clk); start_op(16'h007F, 16'h0001, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0); end_op();
        @(negedge Clk); start_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1); end_op();
        @(negedge Clk); start_op(16'h0005, 16'h0007, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0); end_op();
        @(negedge Clk); start_op(16'h0080, 16'h0001, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0); end_op();

        // Re-pulse Start and change the operands while the operation is busy.
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            @(negedge Clk); A = 16'($urandom); B = 16'($urandom); Sel = 1'($urandom); Start = 1'b1;
            @(negedge Clk); A = 16'($urandom); B = 16'($urandom); Sel = ~Sel; Start = 1'b1;
            end_op();
        end

        // Assert reset one cycle after Start, away from any clock edge.
        @(negedge Clk); start_op(16'h1234, 16'h5678, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge Clk); Start = 1'b0;
        @(posedge Clk); #2;
        Rst_n = 1'b0;
        #1;
        rst_chk("midrun");
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        for (int k = 0; k < 4; k++) buntil[k] = -1;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (10) @(negedge Clk);
        start_op(16'h00C3, 16'h003D, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0); end_op();

        // Isolated random operations.
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            end_op();
        end

        // Hold Start high with new random operands every cycle. Each instance
        // accepts an operation every NCH+2 edges, counted from the first edge.
        @(negedge Clk);
        t0 = cyc + 1;
        for (int i = 0; i < 60; i++) begin
            A = 16'($urandom); B = 16'($urandom); Sel = 1'($urandom); Start = 1'b1;
            en = cyc + 1;
            for (int k = 0; k < 4; k++) begin
                if (((en - t0) % (NCH_K[k] + 2)) == 0) push_k(k, en, model(W_K[k], A, B, Sel));
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        repeat (14) @(negedge Clk);

        chk("pending_results", 0, 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_sub_seq.md
ADD_SUB_SEQ -- requirements
Module: add_sub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 SHALL have parameter CHUNK, default 4, bits processed per cycle; WIDTH mod CHUNK SHALL be 0; NCH = WIDTH/CHUNK.
REQ-003 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port A  input  WIDTH  operand A.
REQ-007 SHALL have port B  input  WIDTH  operand B.
REQ-008 SHALL have port Sel  input  1  0 = A+B, 1 = A-B (two's complement).
REQ-009 SHALL have port Busy  output  1  high while in RUN.
REQ-010 SHALL have port Done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port S  output  WIDTH  result.
REQ-012 SHALL have port Cout  output  1  carry out of MSB (subtract: 1 = no borrow, A>=B unsigned).
REQ-013 SHALL have port Ovf  output  1  signed overflow.
REQ-014 SHALL have port Zero  output  1  S == 0.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE + Start=1 at edge: latch A, B, Sel; carry register <= Sel; chunk index <= 0; go RUN.
REQ-017 IDLE + Start=0: stay IDLE.
REQ-018 Each RUN edge: add chunk i of A and (Sel ? ~B : B) chunk i plus carry register; store CHUNK sum bits; update carry register; index increments.
REQ-019 Edge processing chunk NCH-1: go DONE; load S, Cout, Ovf, Zero from the completed result.
REQ-020 DONE: Done=1 for exactly one cycle; next edge returns to IDLE unconditionally.
REQ-021 Latency: Start sampled at edge t -> Done high in cycle following edge t+NCH (NCH+1 edges after Start); WIDTH=8, CHUNK=4 -> Done 3 cycles after Start edge.
REQ-022 Start while in RUN or DONE SHALL be ignored (no latch, no restart); A/B/Sel changes after acceptance SHALL not affect the result.
REQ-023 S, Cout, Ovf, Zero SHALL change only on the edge entering DONE and hold until the next completion.
REQ-024 Ovf = carry into MSB XOR carry out of MSB.
REQ-025 Arithmetic modulo 2^WIDTH; no saturation.
REQ-026 CHUNK = WIDTH SHALL give NCH=1 (Done 2 cycles after Start edge); CHUNK=1 SHALL give bit-serial operation.
REQ-027 Start held high continuously SHALL start a new operation at each IDLE edge (back-to-back period NCH+2 cycles).

Reset
REQ-028 Rst_n=0 SHALL immediately (asynchronously) force IDLE, Busy=0, Done=0, S=0, Cout=0, Ovf=0, Zero=0, internal carry/index/operands=0.
REQ-029 Reset mid-RUN SHALL abandon the operation; no Done produced afterward.
REQ-030 Start sampled on first edge after Rst_n deasserts SHALL be accepted normally.

Verification (WIDTH=8, CHUNK=4)
REQ-031 A=0x3C, B=0x05, Sel=0 -> S=0x41, Cout=0, Ovf=0, Zero=0; Done 3 cycles after Start edge, single pulse.
REQ-032 A=0x7F, B=0x01, Sel=0 -> S=0x80, Cout=0, Ovf=1; A=0xFF, B=0x01, Sel=0 -> S=0x00, Cout=1, Ovf=0, Zero=1.
REQ-033 A=0x05, B=0x07, Sel=1 -> S=0xFE, Cout=0, Ovf=0; A=0x80, B=0x01, Sel=1 -> S=0x7F, Cout=1, Ovf=1.
REQ-034 Start re-pulsed with new A/B during Busy, A/B changed mid-RUN -> ignored; result equals first operation's value.
REQ-035 Rst_n low one cycle after Start -> Busy=0, all outputs 0 without waiting for edge; no Done follows; next Start completes correctly.
REQ-036 Random sweep, WIDTH/CHUNK in {8/4, 8/1, 16/8, 8/8}: S, Cout, Ovf, Zero match reference model; Done timing matches REQ-021.
